seq_ctrl: RTL and testbench

Parametrised multi-step power-up/configuration sequencer. It drives an ordered chain of up to NUM_SEQ sub-blocks (clock setup, ADC config, link training, …) through a ready/start/done handshake. Over a fixed-order, single-shot sequencer it adds:

- runtime step skipping via a latched enable mask
- separate ready and done timeouts
- bounded retry of steps that time out on done
- re-triggerable runs and abort
- per-step status flags

It sits between board-level control registers and the individual init engines.

---
 rtl/seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_seq_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/seq_ctrl.sv
// rtl/seq_ctrl.sv - multi-step power-up sequencer with masking, timeouts, retries and abort
module seq_ctrl #(
  parameter int          NUM_SEQ     = 4,
  parameter logic [31:0] RDY_CYCLES  = 32'd1000,
  parameter logic [31:0] DONE_CYCLES = 32'd100000,
  parameter int          MAX_RETRIES = 0,
  parameter bit          AUTO_START  = 1'b1,
  parameter int          IDX_W       = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [NUM_SEQ-1:0] enable_mask,
  input  logic [NUM_SEQ-1:0] seq_rdy,
  input  logic [NUM_SEQ-1:0] seq_done,
  output logic [NUM_SEQ-1:0] seq_start,
  output logic [IDX_W-1:0]   step_idx,
  output logic               busy,
  output logic               done,
  output logic [NUM_SEQ-1:0] ok_flags,
  output logic [NUM_SEQ-1:0] timeout_flags,
  output logic               aborted
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, FINISHED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [NUM_SEQ-1:0] mask_q, mask_d;
  logic [NUM_SEQ-1:0] ok_q, ok_d;
  logic [NUM_SEQ-1:0] to_q, to_d;
  logic               aborted_q, aborted_d;
  logic               auto_q;

  // Returns {found, index} of the lowest set bit of m at or above lo.
  function automatic logic [IDX_W:0] pick(input logic [NUM_SEQ-1:0] m, input int lo);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = NUM_SEQ - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, IDX_W'(i)};
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      retry_q   <= '0;
      mask_q    <= '0;
      ok_q      <= '0;
      to_q      <= '0;
      aborted_q <= 1'b0;
      auto_q    <= AUTO_START;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      mask_q    <= mask_d;
      ok_q      <= ok_d;
      to_q      <= to_d;
      aborted_q <= aborted_d;
      auto_q    <= 1'b0;
    end
  end

  always_comb begin
    logic [IDX_W:0] nxt;
    logic [IDX_W:0] first;
    logic           adv;
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    mask_d    = mask_q;
    ok_d      = ok_q;
    to_d      = to_q;
    aborted_d = aborted_q;
    adv       = 1'b0;
    nxt       = pick(mask_q, int'(idx_q) + 1);
    first     = pick(enable_mask, 0);
    case (state_q)
      IDLE, FINISHED: begin
        if (start || auto_q) begin
          mask_d    = enable_mask;
          ok_d      = '0;
          to_d      = '0;
          aborted_d = 1'b0;
          retry_d   = '0;
          cnt_d     = RDY_CYCLES;
          if (first[IDX_W]) begin
            idx_d   = first[IDX_W-1:0];
            state_d = ARM;
          end else begin
            state_d = FINISHED;
          end
        end
      end
      ARM: begin
        if (abort) begin
          state_d   = FINISHED;
          aborted_d = 1'b1;
        end else if (seq_rdy[idx_q]) begin
          state_d = RUN;
          cnt_d   = DONE_CYCLES;
        end else if (cnt_q == 32'd0) begin
          to_d[idx_q] = 1'b1;
          adv         = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d   = FINISHED;
          aborted_d = 1'b1;
        end else if (seq_done[idx_q]) begin
          ok_d[idx_q] = 1'b1;
          adv         = 1'b1;
        end else if (cnt_q == 32'd0 && int'(retry_q) < MAX_RETRIES) begin
          retry_d = retry_q + 4'd1;
          state_d = ARM;
          cnt_d   = RDY_CYCLES;
        end else if (cnt_q == 32'd0) begin
          to_d[idx_q] = 1'b1;
          adv         = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Skipped steps cost nothing: jump straight to the next enabled index.
    if (adv) begin
      if (nxt[IDX_W]) begin
        idx_d   = nxt[IDX_W-1:0];
        state_d = ARM;
        cnt_d   = RDY_CYCLES;
        retry_d = '0;
      end else begin
        state_d = FINISHED;
      end
    end
  end

  always_comb begin
    busy          = (state_q == ARM) || (state_q == RUN);
    done          = (state_q == FINISHED);
    step_idx      = idx_q;
    ok_flags      = ok_q;
    timeout_flags = to_q;
    aborted       = aborted_q;
    seq_start     = '0;
    for (int i = 0; i < NUM_SEQ; i++) begin
      seq_start[i] = (state_q == RUN) && (idx_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// tb/tb_seq_ctrl.sv - directed self-checking bench for seq_ctrl
module tb_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] enable_mask, seq_rdy, seq_done;
  logic [3:0] seq_start, ok_flags, timeout_flags;
  logic [1:0] step_idx;
  logic       busy, done, aborted;
  int         vectors = 0;
  int         errs = 0;

  seq_ctrl #(
    .NUM_SEQ(4), .RDY_CYCLES(32'd3), .DONE_CYCLES(32'd2),
    .MAX_RETRIES(1), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .enable_mask(enable_mask), .seq_rdy(seq_rdy), .seq_done(seq_done),
    .seq_start(seq_start), .step_idx(step_idx), .busy(busy), .done(done),
    .ok_flags(ok_flags), .timeout_flags(timeout_flags), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs the status outputs: {busy, done, aborted, step_idx, seq_start, ok, timeout}
  function automatic logic [31:0] st();
    return {17'd0, busy, done, aborted, step_idx, seq_start, ok_flags, timeout_flags};
  endfunction

  function automatic logic [31:0] mk(input logic b, input logic d, input logic a,
                                     input logic [1:0] ix, input logic [3:0] ss,
                                     input logic [3:0] ok, input logic [3:0] to);
    return {17'd0, b, d, a, ix, ss, ok, to};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    enable_mask = 4'hF; seq_rdy = 4'hF; seq_done = 4'hF;
    tick(); tick();
    chk("reset", st(), mk(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0));

    // all steps responsive, auto start
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_arm", st(), mk(1, 0, 0, 2'(k), 4'h0, 4'((1 << k) - 1), 4'h0));
      tick();
      chk("t1_run", {28'd0, seq_start}, 32'(1 << k));
    end
    tick();
    chk("t1_end", st(), mk(0, 1, 0, 2'd3, 4'h0, 4'hF, 4'h0));

    // skipped steps
    enable_mask = 4'b1010; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_arm1", st(), mk(1, 0, 0, 2'd1, 4'h0, 4'h0, 4'h0));
    tick(); chk("t2_run1", {28'd0, seq_start}, 32'h2);
    tick(); chk("t2_arm3", st(), mk(1, 0, 0, 2'd3, 4'h0, 4'h2, 4'h0));
    tick(); chk("t2_run3", {28'd0, seq_start}, 32'h8);
    tick(); chk("t2_end", st(), mk(0, 1, 0, 2'd3, 4'h0, 4'hA, 4'h0));

    // ready timeout on step 1 after 4 ARM cycles
    enable_mask = 4'hF; seq_rdy = 4'b1101; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk("t3_run0", {28'd0, seq_start}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick(); chk("t3_arm1", st(), mk(1, 0, 0, 2'd1, 4'h0, 4'h1, 4'h0));
    end
    tick(); chk("t3_arm2", st(), mk(1, 0, 0, 2'd2, 4'h0, 4'h1, 4'h2));
    tick(); tick(); tick(); tick();
    chk("t3_end", st(), mk(0, 1, 0, 2'd3, 4'h0, 4'hD, 4'h2));

    // retry then success on step 0
    seq_rdy = 4'hF; seq_done = 4'b1110; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_arm0", st(), mk(1, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0));
    for (int k = 0; k < 3; k++) begin
      tick(); chk("t4_run_a", {28'd0, seq_start}, 32'h1);
    end
    tick(); chk("t4_rearm", st(), mk(1, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0));
    seq_done = 4'hF;
    tick(); chk("t4_run_b", {28'd0, seq_start}, 32'h1);
    tick(); chk("t4_arm1", st(), mk(1, 0, 0, 2'd1, 4'h0, 4'h1, 4'h0));
    for (int k = 0; k < 6; k++) tick();
    chk("t4_end", st(), mk(0, 1, 0, 2'd3, 4'h0, 4'hF, 4'h0));

    // abort colliding with done at step 2
    seq_done = 4'b1011; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t5_run2", st(), mk(1, 0, 0, 2'd2, 4'h4, 4'h3, 4'h0));
    abort = 1'b1; seq_done = 4'hF;
    tick(); abort = 1'b0;
    chk("t5_abort", st(), mk(0, 1, 1, 2'd2, 4'h0, 4'h3, 4'h0));
    abort = 1'b1;
    tick();
    chk("t5_abort_fin", st(), mk(0, 1, 1, 2'd2, 4'h0, 4'h3, 4'h0));
    start = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    chk("t5_restart", st(), mk(1, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0));

    // reset mid-run, then auto start again
    tick(); tick(); tick();
    chk("t6_run1", st(), mk(1, 0, 0, 2'd1, 4'h2, 4'h1, 4'h0));
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("t6_reset", st(), mk(0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0));
    tick(); chk("t6_auto", st(), mk(1, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0));
    tick(); chk("t6_run0", {28'd0, seq_start}, 32'h1);
    for (int k = 0; k < 7; k++) tick();
    chk("t6_end", st(), mk(0, 1, 0, 2'd3, 4'h0, 4'hF, 4'h0));

    // empty mask finishes at once
    enable_mask = 4'h0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t7_empty", st(), mk(0, 1, 0, 2'd3, 4'h0, 4'h0, 4'h0));

    // retries exhausted: done timeout on step 0
    enable_mask = 4'h1; seq_done = 4'h0; start = 1'b1;
    tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chk("t8_last_run", {28'd0, seq_start}, 32'h1);
    tick();
    chk("t8_end", st(), mk(0, 1, 0, 2'd0, 4'h0, 4'h0, 4'h1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
